// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the ID/EX hazard unit: forwarding-select encoding
// and default register index width.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_ID_W_DEFAULT = 5;
  localparam int unsigned FWD_SEL_W        = 2;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard_fwd_match.sv
// One source operand's priority comparator against EX/MEM/WB destinations;
// also flags a load-use hazard when the youngest match is a load in EX.
module fwd_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ID_W = REG_ID_W_DEFAULT
) (
  input  logic                 rs_used,
  input  logic [REG_ID_W-1:0]  rs,
  input  logic                 ex_valid,
  input  logic                 ex_wen,
  input  logic                 ex_is_load,
  input  logic [REG_ID_W-1:0]  ex_rd,
  input  logic                 mem_valid,
  input  logic                 mem_wen,
  input  logic [REG_ID_W-1:0]  mem_rd,
  input  logic                 wb_valid,
  input  logic                 wb_wen,
  input  logic [REG_ID_W-1:0]  wb_rd,
  output logic [FWD_SEL_W-1:0] sel,
  output logic                 load_use
);

  logic     rs_live;
  logic     hit_ex;
  logic     hit_mem;
  logic     hit_wb;
  fwd_sel_e sel_e;

  // x0 is hardwired zero: it never forwards and never stalls
  assign rs_live = rs_used && (rs != '0);
  assign hit_ex  = rs_live && ex_valid  && ex_wen  && (rs == ex_rd);
  assign hit_mem = rs_live && mem_valid && mem_wen && (rs == mem_rd);
  assign hit_wb  = rs_live && wb_valid  && wb_wen  && (rs == wb_rd);

  always_comb begin
    sel_e = FWD_RF;
    if (hit_ex)       sel_e = FWD_EX;
    else if (hit_mem) sel_e = FWD_MEM;
    else if (hit_wb)  sel_e = FWD_WB;
  end

  assign sel      = sel_e;
  assign load_use = hit_ex && ex_is_load;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-operand forwarding selects, load-use detection, MDU
// register scoreboard (RAW/WAW/structural), stall perf counter and stall watchdog.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ID_W      = REG_ID_W_DEFAULT,
  parameter int unsigned NUM_RS        = 2,
  parameter int unsigned PERF_W        = 32,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [NUM_RS*REG_ID_W-1:0]   id_rs,
  input  logic [NUM_RS-1:0]            id_rs_used,
  input  logic [REG_ID_W-1:0]          id_rd,
  input  logic                         id_rd_wen,
  input  logic                         id_is_mdu,
  input  logic                         ex_valid,
  input  logic                         ex_wen,
  input  logic                         ex_is_load,
  input  logic [REG_ID_W-1:0]          ex_rd,
  input  logic                         mem_valid,
  input  logic                         mem_wen,
  input  logic [REG_ID_W-1:0]          mem_rd,
  input  logic                         wb_valid,
  input  logic                         wb_wen,
  input  logic [REG_ID_W-1:0]          wb_rd,
  input  logic                         mdu_wb_valid,
  input  logic [REG_ID_W-1:0]          mdu_wb_rd,
  output logic [NUM_RS*FWD_SEL_W-1:0]  fwd_sel,
  output logic                         stall,
  output logic [PERF_W-1:0]            stall_cycles,
  output logic                         hazard_timeout
);

  localparam int unsigned NUM_REGS = 1 << REG_ID_W;
  localparam int unsigned CONSEC_W = $clog2(STALL_TIMEOUT + 1);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                mdu_busy;
  logic [CONSEC_W-1:0] consec;
  logic [NUM_RS-1:0]   load_use_vec;
  logic [NUM_RS-1:0]   raw_vec;
  logic                waw;
  logic                structural;
  logic                issue;
  logic                issue_sets_rd;

  for (genvar g = 0; g < NUM_RS; g++) begin : g_rs
    fwd_match #(.REG_ID_W(REG_ID_W)) u_fwd_match (
      .rs_used    (id_rs_used[g]),
      .rs         (id_rs[g*REG_ID_W +: REG_ID_W]),
      .ex_valid   (ex_valid),
      .ex_wen     (ex_wen),
      .ex_is_load (ex_is_load),
      .ex_rd      (ex_rd),
      .mem_valid  (mem_valid),
      .mem_wen    (mem_wen),
      .mem_rd     (mem_rd),
      .wb_valid   (wb_valid),
      .wb_wen     (wb_wen),
      .wb_rd      (wb_rd),
      .sel        (fwd_sel[g*FWD_SEL_W +: FWD_SEL_W]),
      .load_use   (load_use_vec[g])
    );
    // busy[0] is never set, so x0 cannot raise a RAW stall
    assign raw_vec[g] = id_rs_used[g] && busy[id_rs[g*REG_ID_W +: REG_ID_W]];
  end

  assign waw           = id_rd_wen && (id_rd != '0) && busy[id_rd];
  assign structural    = id_is_mdu && mdu_busy;
  assign stall         = id_valid && ((|load_use_vec) || (|raw_vec) || waw || structural);
  assign issue         = id_valid && !stall && id_is_mdu;
  assign issue_sets_rd = issue && id_rd_wen && (id_rd != '0);

  // Issue set is applied after the writeback clear so it wins on a shared index
  always_comb begin
    busy_nxt = busy;
    if (mdu_wb_valid)  busy_nxt[mdu_wb_rd] = 1'b0;
    if (issue_sets_rd) busy_nxt[id_rd]     = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      mdu_busy <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (issue)             mdu_busy <= 1'b1;
      else if (mdu_wb_valid) mdu_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles   <= '0;
      consec         <= '0;
      hazard_timeout <= 1'b0;
    end else begin
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + PERF_W'(1);
      if (!stall) begin
        consec <= '0;
      end else if (consec != CONSEC_W'(STALL_TIMEOUT)) begin
        consec <= consec + CONSEC_W'(1);
        if (consec == CONSEC_W'(STALL_TIMEOUT - 1)) hazard_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

  localparam int unsigned REG_ID_W = 5;
  localparam int unsigned NUM_RS   = 2;
  localparam int unsigned PERF_W   = 32;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       id_valid;
  logic [NUM_RS*REG_ID_W-1:0] id_rs;
  logic [NUM_RS-1:0]          id_rs_used;
  logic [REG_ID_W-1:0]        id_rd;
  logic                       id_rd_wen;
  logic                       id_is_mdu;
  logic                       ex_valid, ex_wen, ex_is_load;
  logic [REG_ID_W-1:0]        ex_rd;
  logic                       mem_valid, mem_wen;
  logic [REG_ID_W-1:0]        mem_rd;
  logic                       wb_valid, wb_wen;
  logic [REG_ID_W-1:0]        wb_rd;
  logic                       mdu_wb_valid;
  logic [REG_ID_W-1:0]        mdu_wb_rd;
  logic [NUM_RS*2-1:0]        fwd_sel;
  logic                       stall;
  logic [PERF_W-1:0]          stall_cycles;
  logic                       hazard_timeout;

  int checks   = 0;
  int failures = 0;

  hazard_scoreboard #(
    .REG_ID_W      (REG_ID_W),
    .NUM_RS        (NUM_RS),
    .PERF_W        (PERF_W),
    .STALL_TIMEOUT (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rs_used     (id_rs_used),
    .id_rd          (id_rd),
    .id_rd_wen      (id_rd_wen),
    .id_is_mdu      (id_is_mdu),
    .ex_valid       (ex_valid),
    .ex_wen         (ex_wen),
    .ex_is_load     (ex_is_load),
    .ex_rd          (ex_rd),
    .mem_valid      (mem_valid),
    .mem_wen        (mem_wen),
    .mem_rd         (mem_rd),
    .wb_valid       (wb_valid),
    .wb_wen         (wb_wen),
    .wb_rd          (wb_rd),
    .mdu_wb_valid   (mdu_wb_valid),
    .mdu_wb_rd      (mdu_wb_rd),
    .fwd_sel        (fwd_sel),
    .stall          (stall),
    .stall_cycles   (stall_cycles),
    .hazard_timeout (hazard_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_rd_wen = 0; id_is_mdu = 0;
    ex_valid = 0; ex_wen = 0; ex_is_load = 0; ex_rd = '0;
    mem_valid = 0; mem_wen = 0; mem_rd = '0;
    wb_valid = 0; wb_wen = 0; wb_rd = '0;
    mdu_wb_valid = 0; mdu_wb_rd = '0;
  endtask

  task automatic read_rs1(input logic [REG_ID_W-1:0] r);
    id_valid = 1; id_is_mdu = 0; id_rd_wen = 0; id_rd = '0;
    id_rs = {REG_ID_W'(0), r}; id_rs_used = 2'b01;
  endtask

  task automatic issue_mdu(input logic [REG_ID_W-1:0] rd);
    id_valid = 1; id_is_mdu = 1; id_rd_wen = 1; id_rd = rd; id_rs_used = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_sc", stall_cycles, 0);
    check("rst_to", 32'(hazard_timeout), 0);
    check("rst_fwd", 32'(fwd_sel), 0);

    // forwarding priority
    read_rs1(5);
    ex_valid = 1; ex_wen = 1; ex_rd = 5;
    #1;
    check("fwd_ex", 32'(fwd_sel), 1);
    check("fwd_ex_stall", 32'(stall), 0);
    mem_valid = 1; mem_wen = 1; mem_rd = 5;
    #1;
    check("fwd_ex_over_mem", 32'(fwd_sel), 1);
    ex_valid = 0;
    #1;
    check("fwd_mem", 32'(fwd_sel), 2);
    mem_valid = 0; wb_valid = 1; wb_wen = 1; wb_rd = 5;
    #1;
    check("fwd_wb", 32'(fwd_sel), 3);
    wb_wen = 0;
    #1;
    check("fwd_wb_nowen", 32'(fwd_sel), 0);

    // x0 never forwards
    clear_inputs();
    read_rs1(0);
    ex_valid = 1; ex_wen = 1; ex_rd = 0;
    #1;
    check("x0_fwd", 32'(fwd_sel), 0);
    check("x0_stall", 32'(stall), 0);

    // load-use on rs2
    clear_inputs();
    id_valid = 1; id_rs = {REG_ID_W'(7), REG_ID_W'(0)}; id_rs_used = 2'b10;
    ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_rd = 7;
    #1;
    check("lu_stall", 32'(stall), 1);
    tick();
    ex_valid = 0; ex_is_load = 0;
    mem_valid = 1; mem_wen = 1; mem_rd = 7;
    #1;
    check("lu_after_stall", 32'(stall), 0);
    check("lu_after_fwd", 32'(fwd_sel), 32'h8);
    check("lu_sc", stall_cycles, 1);

    // MDU scoreboard
    clear_inputs();
    issue_mdu(9);
    #1;
    check("div_issue_stall", 32'(stall), 0);
    tick();
    read_rs1(9);
    #1;
    check("raw_stall0", 32'(stall), 1);
    tick();
    check("raw_stall1", 32'(stall), 1);
    tick();
    issue_mdu(10);
    #1;
    check("struct_stall", 32'(stall), 1);
    id_is_mdu = 0; id_rd = 9; id_rd_wen = 1;
    #1;
    check("waw_stall", 32'(stall), 1);
    read_rs1(9);
    mdu_wb_valid = 1; mdu_wb_rd = 9;
    #1;
    check("raw_wb_cycle", 32'(stall), 1);
    tick();
    mdu_wb_valid = 0;
    #1;
    check("raw_cleared", 32'(stall), 0);
    issue_mdu(12);
    id_valid = 0;
    #1;
    check("sc_after_mdu", stall_cycles, 4);

    // watchdog with STALL_TIMEOUT=8
    issue_mdu(3);
    tick();
    read_rs1(3);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("to_k%0d", k), 32'(hazard_timeout), (k >= 8) ? 1 : 0);
    end
    mdu_wb_valid = 1; mdu_wb_rd = 3;
    tick();
    mdu_wb_valid = 0;
    #1;
    check("to_stall_clear", 32'(stall), 0);
    check("to_sticky0", 32'(hazard_timeout), 1);
    tick();
    check("to_sticky1", 32'(hazard_timeout), 1);
    check("sc_after_to", stall_cycles, 15);

    // async reset clears scoreboard
    issue_mdu(9);
    tick();
    read_rs1(9);
    #1;
    check("pre_rst_stall", 32'(stall), 1);
    rst = 1;
    #1;
    check("async_rst_stall", 32'(stall), 0);
    check("async_rst_to", 32'(hazard_timeout), 0);
    check("async_rst_sc", stall_cycles, 0);
    tick();
    rst = 0;
    tick();
    check("post_rst_stall", 32'(stall), 0);
    id_is_mdu = 1;
    #1;
    check("post_rst_mdu_free", 32'(stall), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
